// File: rtl/hamming_pkg.sv
// hamming_pkg: shared Hamming(15,11) definitions for the encoder, corrector and serial receiver.
package hamming_pkg;
  localparam int N_BITS_DEF = 15;
  typedef enum logic [1:0] {OCIOSO, RECEBENDO, PARIDADE, PARADA} estado_t;
  function automatic logic paridade_global(input logic [N_BITS_DEF-1:0] w);
    return ^w;
  endfunction
endpackage

// File: rtl/recebe_hamming_if.sv
// recebe_hamming_if: serial line in, codeword out under valid/ack, plus error flags.
interface recebe_hamming_if #(parameter int N_BITS = hamming_pkg::N_BITS_DEF);
  logic              bit_en;
  logic              serial;
  logic              ack;
  logic [N_BITS-1:0] palavra;
  logic              palavra_valida;
  logic              erro_quadro;
  logic              overrun;
  logic              erro_paridade;
  modport master (output bit_en, serial, ack, input palavra, palavra_valida, erro_quadro, overrun, erro_paridade);
  modport slave (input bit_en, serial, ack, output palavra, palavra_valida, erro_quadro, overrun, erro_paridade);
endinterface

// File: rtl/recebe_hamming_contador_timeout.sv
// contador_timeout: counts clk cycles since the last clear; expira flags the final allowed cycle.
module contador_timeout #(
  parameter int TIMEOUT_CICLOS = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expira
);
  localparam int W = $clog2(TIMEOUT_CICLOS);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = (clear | ~enable) ? '0 : cnt_q + W'(1);
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign expira = enable & (cnt_q == W'(TIMEOUT_CICLOS - 1));
endmodule

// File: rtl/recebe_hamming.sv
// recebe_hamming: start/stop serial deframer producing a 15-bit codeword, bit 0 first.
// HAMMING_PARIDADE_GLOBAL_EN adds an even-parity bit after the codeword, reported on erro_paridade.
module recebe_hamming
  import hamming_pkg::*;
#(
  parameter int N_BITS = N_BITS_DEF,
  parameter int TIMEOUT_CICLOS = 1024
) (
  input logic clk,
  input logic rst,
  recebe_hamming_if.slave bus
);
  localparam int CW = $clog2(N_BITS);
  estado_t estado_q, estado_d;
  logic [CW-1:0] cont_q, cont_d;
  logic [N_BITS-1:0] shift_q, shift_d, palavra_q, palavra_d;
  logic valida_q, valida_d, erro_q, erro_d, over_q, over_d, armado_q, armado_d;
  logic ativo, expira, aborta, ultimo, bom, ruim;
  assign ativo = estado_q != OCIOSO;
  assign aborta = expira & ~bus.bit_en;
  assign ultimo = cont_q == CW'(N_BITS - 1);
  assign bom = (estado_q == PARADA) & bus.bit_en & bus.serial;
  assign ruim = (estado_q == PARADA) & bus.bit_en & ~bus.serial;
  contador_timeout #(.TIMEOUT_CICLOS(TIMEOUT_CICLOS)) u_timeout (
    .clk(clk), .rst(rst), .clear(bus.bit_en), .enable(ativo), .expira(expira)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) estado_q <= OCIOSO;
    else estado_q <= estado_d;
  always_comb begin
    estado_d = estado_q;
    if (aborta) estado_d = OCIOSO;
    else if (bus.bit_en)
      case (estado_q)
        OCIOSO: estado_d = (armado_q & ~bus.serial) ? RECEBENDO : OCIOSO;
`ifdef HAMMING_PARIDADE_GLOBAL_EN
        RECEBENDO: estado_d = ultimo ? PARIDADE : RECEBENDO;
        PARIDADE: estado_d = PARADA;
`else
        RECEBENDO: estado_d = ultimo ? PARADA : RECEBENDO;
`endif
        default: estado_d = OCIOSO;
      endcase
  end
  // A bad stop bit disarms start detection until the line is seen idle again.
  always_comb begin
    cont_d = (estado_q == RECEBENDO) ? cont_q + CW'(bus.bit_en) : '0;
    shift_d = shift_q;
    if ((estado_q == RECEBENDO) & bus.bit_en) shift_d[cont_q] = bus.serial;
    armado_d = ruim ? 1'b0 : ((estado_q == OCIOSO) & bus.bit_en & bus.serial) ? 1'b1 : armado_q;
    palavra_d = bom ? shift_q : palavra_q;
    valida_d = bom | (valida_q & ~bus.ack);
    over_d = over_q | (bom & valida_q & ~bus.ack);
    erro_d = ruim | aborta;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cont_q <= '0;
      shift_q <= '0;
      armado_q <= 1'b1;
      palavra_q <= '0;
      valida_q <= 1'b0;
      over_q <= 1'b0;
      erro_q <= 1'b0;
    end else begin
      cont_q <= cont_d;
      shift_q <= shift_d;
      armado_q <= armado_d;
      palavra_q <= palavra_d;
      valida_q <= valida_d;
      over_q <= over_d;
      erro_q <= erro_d;
    end
`ifdef HAMMING_PARIDADE_GLOBAL_EN
  logic par_q, par_d, epar_q, epar_d;
  always_comb begin
    par_d = ((estado_q == PARIDADE) & bus.bit_en) ? bus.serial : par_q;
    epar_d = bom ? paridade_global(shift_q) ^ par_q : epar_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      par_q <= 1'b0;
      epar_q <= 1'b0;
    end else begin
      par_q <= par_d;
      epar_q <= epar_d;
    end
  assign bus.erro_paridade = epar_q;
`else
  assign bus.erro_paridade = 1'b0;
`endif
  assign bus.palavra = palavra_q;
  assign bus.palavra_valida = valida_q;
  assign bus.erro_quadro = erro_q;
  assign bus.overrun = over_q;
endmodule

// File: tb/tb_recebe_hamming.sv
// tb_recebe_hamming: directed vector table plus hand sequences for reset, ack race, timeout and parity.
module tb_recebe_hamming;
`ifdef HAMMING_PARIDADE_GLOBAL_EN
  localparam bit USA_PAR = 1'b1;
`else
  localparam bit USA_PAR = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst;
  int pass_n = 0;
  int total_n = 0;
  recebe_hamming_if #(.N_BITS(15)) bus ();
  recebe_hamming #(.N_BITS(15), .TIMEOUT_CICLOS(8)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  typedef struct {
    logic [14:0] w;
    logic        stop;
    logic        ack_after;
    logic [14:0] pal;
    logic        val;
    logic        err;
    logic        ovr;
    logic        val_after;
  } vec_t;
  vec_t tab [4];
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string nome, input logic [31:0] got, input logic [31:0] exp);
    total_n++;
    if (got === exp) pass_n++;
    else $display("FAIL %s: got %0h expected %0h", nome, got, exp);
  endtask
  task automatic send_bit(input logic b, input int gap = 3, input logic a = 1'b0);
    repeat (gap) tick();
    bus.bit_en = 1'b1;
    bus.serial = b;
    bus.ack = a;
    tick();
    bus.bit_en = 1'b0;
    bus.serial = 1'b1;
    bus.ack = 1'b0;
  endtask
  task automatic send_frame(input logic [14:0] w, input logic stop, input logic par,
                            input logic a = 1'b0, input int gi = -1);
    send_bit(1'b1);
    send_bit(1'b0);
    for (int i = 0; i < 15; i++) send_bit(w[i], (i == gi) ? 7 : 3);
    if (USA_PAR) send_bit(par);
    send_bit(stop, 3, a);
  endtask
  task automatic chk_outs(input string p, input logic [14:0] pal, input logic val,
                          input logic err, input logic ovr, input logic epar);
    chk({p, " palavra"}, bus.palavra, pal);
    chk({p, " valida"}, bus.palavra_valida, val);
    chk({p, " erro_quadro"}, bus.erro_quadro, err);
    chk({p, " overrun"}, bus.overrun, ovr);
    chk({p, " erro_paridade"}, bus.erro_paridade, epar);
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    tab[0] = '{15'h2A5B, 1'b0, 1'b0, 15'h0000, 1'b0, 1'b1, 1'b0, 1'b0};
    tab[1] = '{15'h2A5B, 1'b1, 1'b1, 15'h2A5B, 1'b1, 1'b0, 1'b0, 1'b0};
    tab[2] = '{15'h0001, 1'b1, 1'b0, 15'h0001, 1'b1, 1'b0, 1'b0, 1'b1};
    tab[3] = '{15'h7FFF, 1'b1, 1'b0, 15'h7FFF, 1'b1, 1'b0, 1'b1, 1'b1};
    rst = 1'b1;
    bus.bit_en = 1'b0;
    bus.serial = 1'b1;
    bus.ack = 1'b0;
    repeat (2) tick();
    chk_outs("reset", 15'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      send_frame(tab[i].w, tab[i].stop, ^tab[i].w);
      chk_outs($sformatf("vec%0d", i), tab[i].pal, tab[i].val, tab[i].err, tab[i].ovr, 1'b0);
      bus.ack = tab[i].ack_after;
      tick();
      bus.ack = 1'b0;
      chk($sformatf("vec%0d valida_depois", i), bus.palavra_valida, tab[i].val_after);
      chk($sformatf("vec%0d erro_quadro_depois", i), bus.erro_quadro, 1'b0);
      chk($sformatf("vec%0d palavra_depois", i), bus.palavra, tab[i].pal);
    end
    rst = 1'b1;
    #2;
    chk_outs("async_rst", 15'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    rst = 1'b0;
    tick();
    send_frame(15'h1234, 1'b1, ^15'h1234);
    chk("ack_race first valida", bus.palavra_valida, 1'b1);
    send_frame(15'h0555, 1'b1, ^15'h0555, 1'b1);
    chk_outs("ack_race", 15'h0555, 1'b1, 1'b0, 1'b0, 1'b0);
    bus.ack = 1'b1;
    tick();
    bus.ack = 1'b0;
    chk("ack_race consumed", bus.palavra_valida, 1'b0);
    send_frame(15'h3C3C, 1'b1, ^15'h3C3C, 1'b0, 3);
    chk_outs("gap_at_expiry", 15'h3C3C, 1'b1, 1'b0, 1'b0, 1'b0);
    bus.ack = 1'b1;
    tick();
    bus.ack = 1'b0;
    send_bit(1'b1);
    send_bit(1'b0);
    for (int i = 0; i < 5; i++) send_bit(i[0]);
    repeat (7) tick();
    chk("timeout early erro_quadro", bus.erro_quadro, 1'b0);
    tick();
    chk("timeout erro_quadro", bus.erro_quadro, 1'b1);
    chk("timeout valida", bus.palavra_valida, 1'b0);
    tick();
    chk("timeout pulse width", bus.erro_quadro, 1'b0);
    send_frame(15'h2A5B, 1'b1, ^15'h2A5B);
    chk_outs("after_timeout", 15'h2A5B, 1'b1, 1'b0, 1'b0, 1'b0);
    bus.ack = 1'b1;
    tick();
    bus.ack = 1'b0;
`ifdef HAMMING_PARIDADE_GLOBAL_EN
    send_frame(15'h0003, 1'b1, 1'b1);
    chk_outs("par_bad", 15'h0003, 1'b1, 1'b0, 1'b0, 1'b1);
    bus.ack = 1'b1;
    tick();
    bus.ack = 1'b0;
    chk("par_bad held", bus.erro_paridade, 1'b1);
    send_frame(15'h0003, 1'b1, 1'b0);
    chk_outs("par_ok", 15'h0003, 1'b1, 1'b0, 1'b0, 1'b0);
`endif
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule
